// File: rtl/load_unit.sv
// Activation tile loader: reads one 4x4 tile from single-port SRAM, zero-pads
// past the feature-map edge and holds it under a valid/ready handshake.
module load_unit #(
  parameter int SRAM_LAT = 2,
  parameter int TILE     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  size_act,
  input  logic [15:0] address_read_base,
  input  logic [7:0]  tile_row,
  input  logic [7:0]  tile_col,
  output logic [15:0] address,
  output logic        enable_sram,
  output logic        wea_sram,
  input  logic [15:0] data_in,
  output logic [63:0] data_tile_1,
  output logic [63:0] data_tile_2,
  output logic [63:0] data_tile_3,
  output logic [63:0] data_tile_4,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic        busy,
  output logic        endsignal
);

  localparam int SLOTS = TILE * TILE;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, VALID} state_t;

  state_t        state_q;
  logic [7:0]    n_q, row_q, col_q;
  logic [15:0]   base_q;
  logic [3:0]    slot_q;
  logic          pad_q;
  logic [2:0]    drain_q;
  logic [15:0]   address_q;
  logic          enable_q;
  logic          tile_valid_q;
  logic          busy_q;

  logic [SRAM_LAT-1:0]       tag_vld_q;
  logic [SRAM_LAT-1:0]       tag_pad_q;
  logic [SRAM_LAT-1:0][3:0]  tag_slot_q;
  logic [15:0][15:0]         tile_q;

  logic [3:0]    slot_d;
  logic [7:0]    n_d, row_d, col_d;
  logic [15:0]   base_d;
  logic [8:0]    row_abs_d, col_abs_d;
  logic [17:0]   prod_d;
  logic          pad_d;
  logic [15:0]   addr_d;

  // Address and pad decision for the slot issued on the next cycle; in IDLE the
  // raw request inputs are used so slot 0 goes out on the cycle after start.
  always_comb begin
    slot_d    = (state_q == IDLE) ? 4'd0 : slot_q + 4'd1;
    n_d       = (state_q == IDLE) ? size_act : n_q;
    base_d    = (state_q == IDLE) ? address_read_base : base_q;
    row_d     = (state_q == IDLE) ? tile_row : row_q;
    col_d     = (state_q == IDLE) ? tile_col : col_q;
    row_abs_d = {1'b0, row_d} + {7'b0, slot_d[3:2]};
    col_abs_d = {1'b0, col_d} + {7'b0, slot_d[1:0]};
    pad_d     = (row_abs_d >= {1'b0, n_d}) || (col_abs_d >= {1'b0, n_d});
    prod_d    = {9'b0, row_abs_d} * {10'b0, n_d};
    addr_d    = base_d + {7'b0, col_abs_d} + prod_d[15:0];
  end

  // Control FSM with registered SRAM interface and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= 8'd0;
      row_q        <= 8'd0;
      col_q        <= 8'd0;
      base_q       <= 16'd0;
      slot_q       <= 4'd0;
      pad_q        <= 1'b0;
      drain_q      <= 3'd0;
      address_q    <= 16'd0;
      enable_q     <= 1'b0;
      tile_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= ISSUE;
            n_q      <= size_act;
            row_q    <= tile_row;
            col_q    <= tile_col;
            base_q   <= address_read_base;
            busy_q   <= 1'b1;
            slot_q   <= slot_d;
            pad_q    <= pad_d;
            enable_q <= ~pad_d;
            if (!pad_d) begin
              address_q <= addr_d;
            end
          end
        end
        ISSUE: begin
          if (slot_q == 4'(SLOTS - 1)) begin
            state_q  <= DRAIN;
            enable_q <= 1'b0;
            drain_q  <= 3'd0;
          end else begin
            slot_q   <= slot_d;
            pad_q    <= pad_d;
            enable_q <= ~pad_d;
            // Padded slots leave the bus address untouched.
            if (!pad_d) begin
              address_q <= addr_d;
            end
          end
        end
        DRAIN: begin
          if (drain_q == 3'(SRAM_LAT - 1)) begin
            state_q      <= VALID;
            tile_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        VALID: begin
          if (tile_ready) begin
            state_q      <= IDLE;
            tile_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Tag pipeline matches each returning SRAM word to its slot, then captures it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q  <= '0;
      tag_pad_q  <= '0;
      tag_slot_q <= '0;
      tile_q     <= '0;
    end else begin
      tag_vld_q[0]  <= (state_q == ISSUE);
      tag_pad_q[0]  <= pad_q;
      tag_slot_q[0] <= slot_q;
      for (int i = 1; i < SRAM_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_pad_q[i]  <= tag_pad_q[i-1];
        tag_slot_q[i] <= tag_slot_q[i-1];
      end
      if (tag_vld_q[SRAM_LAT-1]) begin
        tile_q[tag_slot_q[SRAM_LAT-1]] <= tag_pad_q[SRAM_LAT-1] ? 16'h0000 : data_in;
      end
    end
  end

  assign address     = address_q;
  assign enable_sram = enable_q;
  assign wea_sram    = 1'b0;
  assign tile_valid  = tile_valid_q;
  assign busy        = busy_q;
  // Completion is flagged in the same cycle the consumer takes the tile.
  assign endsignal   = tile_valid_q & tile_ready;
  assign data_tile_1 = {tile_q[0],  tile_q[1],  tile_q[2],  tile_q[3]};
  assign data_tile_2 = {tile_q[4],  tile_q[5],  tile_q[6],  tile_q[7]};
  assign data_tile_3 = {tile_q[8],  tile_q[9],  tile_q[10], tile_q[11]};
  assign data_tile_4 = {tile_q[12], tile_q[13], tile_q[14], tile_q[15]};

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: SRAM model returns mem[a]=a after 2 cycles.
module tb_load_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  size_act, tile_row, tile_col;
  logic [15:0] address_read_base, address, data_in;
  logic        enable_sram, wea_sram, tile_valid, tile_ready, busy, endsignal;
  logic [63:0] data_tile_1, data_tile_2, data_tile_3, data_tile_4;
  logic [15:0] pipe1, pipe2;

  logic [15:0]  exp_addr_q[$];
  logic [255:0] exp_tile_q[$];
  int total = 0, bad = 0, en_cnt = 0, end_cnt = 0, cyc = 0, seen = 0;

  always #5 clk = ~clk;

  load_unit #(.SRAM_LAT(2), .TILE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size_act(size_act),
    .address_read_base(address_read_base), .tile_row(tile_row), .tile_col(tile_col),
    .address(address), .enable_sram(enable_sram), .wea_sram(wea_sram), .data_in(data_in),
    .data_tile_1(data_tile_1), .data_tile_2(data_tile_2),
    .data_tile_3(data_tile_3), .data_tile_4(data_tile_4),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .busy(busy), .endsignal(endsignal)
  );

  // SRAM model, two-cycle read latency, contents equal to address.
  always @(posedge clk) begin
    pipe1 <= enable_sram ? address : 16'hDEAD;
    pipe2 <= pipe1;
  end
  assign data_in = pipe2;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (no expectation available)", name);
  endtask

  // Monitor: pops expected SRAM addresses and tiles as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (enable_sram) begin
        en_cnt++;
        if (exp_addr_q.size() == 0) fail("addr_unexpected");
        else check("addr", address, exp_addr_q.pop_front());
      end
      if (endsignal) end_cnt++;
      if (tile_valid && tile_ready) begin
        if (exp_tile_q.size() == 0) fail("tile_unexpected");
        else check("tile", {data_tile_1, data_tile_2, data_tile_3, data_tile_4},
                   exp_tile_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [7:0] n, input logic [15:0] b, input logic [7:0] r,
                       input logic [7:0] c);
    @(negedge clk);
    size_act = n; address_read_base = b; tile_row = r; tile_col = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    size_act = 8'hFF; address_read_base = 16'hBEEF; tile_row = 8'h55; tile_col = 8'h33;
  endtask

  task automatic wait_valid(output int c);
    c = 1;
    while (c < 200) begin
      @(negedge clk);
      if (tile_valid) break;
      @(posedge clk);
      c++;
    end
    if (c >= 200) fail("wait_valid_timeout");
  endtask

  task automatic push_grid(input logic [15:0] first);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_addr_q.push_back(first + 16'(i * 8 + j));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; tile_ready = 1'b0; size_act = 8'd0;
    address_read_base = 16'd0; tile_row = 8'd0; tile_col = 8'd0;
    #1;
    check("reset_ctrl", {address, enable_sram, wea_sram, tile_valid, busy, endsignal}, 0);
    check("reset_data", {data_tile_1, data_tile_2, data_tile_3, data_tile_4}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // T1: N=8, base 0x0100, tile (2,2)
    tile_ready = 1'b1; en_cnt = 0; end_cnt = 0;
    push_grid(16'h0112);
    exp_tile_q.push_back({64'h0112_0113_0114_0115, 64'h011A_011B_011C_011D,
                          64'h0122_0123_0124_0125, 64'h012A_012B_012C_012D});
    issue(8'd8, 16'h0100, 8'd2, 8'd2);
    wait_valid(cyc);
    check("t1_valid_cycle", cyc, 19);
    @(posedge clk); #1;
    check("t1_busy_after", busy, 0);
    check("t1_reads", en_cnt, 16);
    check("t1_end_pulses", end_cnt, 1);
    check("t1_wea", wea_sram, 0);

    // T2: corner tile (6,6), only a 2x2 region in bounds
    en_cnt = 0; end_cnt = 0;
    exp_addr_q.push_back(16'h0136); exp_addr_q.push_back(16'h0137);
    exp_addr_q.push_back(16'h013E); exp_addr_q.push_back(16'h013F);
    exp_tile_q.push_back({64'h0136_0137_0000_0000, 64'h013E_013F_0000_0000, 64'h0, 64'h0});
    issue(8'd8, 16'h0100, 8'd6, 8'd6);
    wait_valid(cyc);
    check("t2_valid_cycle", cyc, 19);
    @(posedge clk); #1;
    check("t2_reads", en_cnt, 4);
    check("t2_end_pulses", end_cnt, 1);

    // T3: consumer stalls for 10 cycles
    tile_ready = 1'b0; en_cnt = 0; end_cnt = 0;
    push_grid(16'h0200);
    exp_tile_q.push_back({64'h0200_0201_0202_0203, 64'h0208_0209_020A_020B,
                          64'h0210_0211_0212_0213, 64'h0218_0219_021A_021B});
    issue(8'd8, 16'h0200, 8'd0, 8'd0);
    wait_valid(cyc);
    check("t3_valid_cycle", cyc, 19);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check("t3_hold_data", {data_tile_1, data_tile_2, data_tile_3, data_tile_4},
            {64'h0200_0201_0202_0203, 64'h0208_0209_020A_020B,
             64'h0210_0211_0212_0213, 64'h0218_0219_021A_021B});
      check("t3_hold_ctrl", {tile_valid, busy, enable_sram, endsignal}, 4'b1100);
    end
    @(posedge clk); #1;
    tile_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_busy_after", {busy, tile_valid}, 2'b00);
    check("t3_end_pulses", end_cnt, 1);
    check("t3_reads", en_cnt, 16);

    // T4: start at cycle 5 while busy is ignored; later start honoured
    en_cnt = 0; end_cnt = 0;
    exp_addr_q.push_back(16'h010B); exp_addr_q.push_back(16'h010C);
    exp_addr_q.push_back(16'h010D); exp_addr_q.push_back(16'h010E);
    exp_addr_q.push_back(16'h0113); exp_addr_q.push_back(16'h0114);
    exp_addr_q.push_back(16'h0115); exp_addr_q.push_back(16'h0116);
    exp_addr_q.push_back(16'h011B); exp_addr_q.push_back(16'h011C);
    exp_addr_q.push_back(16'h011D); exp_addr_q.push_back(16'h011E);
    exp_addr_q.push_back(16'h0123); exp_addr_q.push_back(16'h0124);
    exp_addr_q.push_back(16'h0125); exp_addr_q.push_back(16'h0126);
    exp_tile_q.push_back({64'h010B_010C_010D_010E, 64'h0113_0114_0115_0116,
                          64'h011B_011C_011D_011E, 64'h0123_0124_0125_0126});
    issue(8'd8, 16'h0100, 8'd1, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; size_act = 8'd8; address_read_base = 16'h0100; tile_row = 8'd0; tile_col = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(cyc);
    @(posedge clk); #1;
    check("t4_busy_after", busy, 0);
    check("t4_reads", en_cnt, 16);
    check("t4_end_pulses", end_cnt, 1);
    en_cnt = 0;
    push_grid(16'h0100);
    exp_tile_q.push_back({64'h0100_0101_0102_0103, 64'h0108_0109_010A_010B,
                          64'h0110_0111_0112_0113, 64'h0118_0119_011A_011B});
    issue(8'd8, 16'h0100, 8'd0, 8'd0);
    wait_valid(cyc);
    check("t4_second_valid_cycle", cyc, 19);
    @(posedge clk); #1;
    check("t4_second_reads", en_cnt, 16);

    // T5: reset during issue slot 7 (cycle 8)
    en_cnt = 0; end_cnt = 0;
    for (int k = 0; k < 8; k++) exp_addr_q.push_back(16'h0112 + 16'((k / 4) * 8 + (k % 4)));
    issue(8'd8, 16'h0100, 8'd2, 8'd2);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_reset_ctrl", {address, enable_sram, wea_sram, tile_valid, busy, endsignal}, 0);
    check("t5_reset_data", {data_tile_1, data_tile_2, data_tile_3, data_tile_4}, 0);
    check("t5_reads_before_reset", en_cnt, 8);
    check("t5_addr_queue_drained", exp_addr_q.size(), 0);
    exp_addr_q.delete();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tile_valid || endsignal || enable_sram || busy) seen++;
    end
    check("t5_quiet_after_reset", seen, 0);
    en_cnt = 0; end_cnt = 0;
    push_grid(16'h0112);
    exp_tile_q.push_back({64'h0112_0113_0114_0115, 64'h011A_011B_011C_011D,
                          64'h0122_0123_0124_0125, 64'h012A_012B_012C_012D});
    issue(8'd8, 16'h0100, 8'd2, 8'd2);
    wait_valid(cyc);
    check("t5_restart_valid_cycle", cyc, 19);
    @(posedge clk); #1;
    check("t5_restart_end_pulses", end_cnt, 1);

    // T6: empty feature map, everything padded
    en_cnt = 0; end_cnt = 0;
    exp_tile_q.push_back(256'h0);
    issue(8'd0, 16'h0100, 8'd0, 8'd0);
    wait_valid(cyc);
    check("t6_valid_cycle", cyc, 19);
    @(posedge clk); #1;
    check("t6_reads", en_cnt, 0);
    check("t6_end_pulses", end_cnt, 1);
    check("t6_queues_empty", {exp_addr_q.size(), exp_tile_q.size()}, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
